rf_snapshot_streamer: RTL and testbench

Captures an atomic snapshot of the CPU's 32 architectural registers (the `RF_data0`…`RF_data31` observation bus exported by `CPU`) on request, then streams the words out one per beat over a valid/ready interface. The CPU writes the observation bus, and this block reads it. It sits beside `CPU` in simulation and FPGA builds, and feeds a UART/trace sink or a bench scoreboard without stalling the pipeline.

---
 rtl/rf_snap_pkg.sv | 7 +
 rtl/rf_snap_bank.sv | 37 +++
 rtl/rf_snapshot_streamer.sv | 178 +++++++++++++++++
 tb/tb_rf_snapshot_streamer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_snap_pkg.sv
// rf_snap_pkg: shared FSM state type and constants for the register-file snapshot streamer.
package rf_snap_pkg;
    typedef enum logic [1:0] {IDLE, SEND, SUM} state_e;
    localparam int         NUM_REGS     = 32;
    localparam logic [5:0] SUM_INDEX    = 6'd32;
    localparam logic [7:0] DROP_CNT_MAX = 8'd255;
endpackage

// File: rtl/rf_snap_bank.sv
// rf_snap_bank: capture bank holding one frozen copy of the register file.
// Ports: clk, reset (async active-low), load_i (capture strobe), wr_data_i (live registers),
//        rd_idx_i (read select), rd_data_o (selected word), sum_o (XOR of bank, RF_SNAP_CHECKSUM_EN only).
module rf_snap_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load_i,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  wr_data_i,
    input  logic [4:0]                       rd_idx_i,
    output logic [DATA_W-1:0]                rd_data_o
`ifdef RF_SNAP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]                sum_o
`endif
);
    import rf_snap_pkg::*;

    logic [NUM_REGS-1:0][DATA_W-1:0] bank_q, bank_d;

    assign bank_d    = load_i ? wr_data_i : bank_q;
    assign rd_data_o = bank_q[rd_idx_i];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bank_q <= '0;
        else        bank_q <= bank_d;
    end

`ifdef RF_SNAP_CHECKSUM_EN
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < NUM_REGS; i++) sum_o = sum_o ^ bank_q[i];
    end
`endif
endmodule

// File: rtl/rf_snapshot_streamer.sv
// rf_snapshot_streamer: atomically captures the 32 CPU registers on snap_req and streams them out over valid/ready.
// Ports: clk, reset (async active-low), RF_data0..RF_data31 (live registers), snap_req (capture request),
//        snap_busy, out_valid/out_ready/out_index/out_data/out_last (registered stream), snap_drop_cnt (saturating).
// Option: define RF_SNAP_CHECKSUM_EN to append a 33rd beat (index 32) carrying the XOR of all captured words.
module rf_snapshot_streamer #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] RF_data0,
    input  logic [DATA_W-1:0] RF_data1,
    input  logic [DATA_W-1:0] RF_data2,
    input  logic [DATA_W-1:0] RF_data3,
    input  logic [DATA_W-1:0] RF_data4,
    input  logic [DATA_W-1:0] RF_data5,
    input  logic [DATA_W-1:0] RF_data6,
    input  logic [DATA_W-1:0] RF_data7,
    input  logic [DATA_W-1:0] RF_data8,
    input  logic [DATA_W-1:0] RF_data9,
    input  logic [DATA_W-1:0] RF_data10,
    input  logic [DATA_W-1:0] RF_data11,
    input  logic [DATA_W-1:0] RF_data12,
    input  logic [DATA_W-1:0] RF_data13,
    input  logic [DATA_W-1:0] RF_data14,
    input  logic [DATA_W-1:0] RF_data15,
    input  logic [DATA_W-1:0] RF_data16,
    input  logic [DATA_W-1:0] RF_data17,
    input  logic [DATA_W-1:0] RF_data18,
    input  logic [DATA_W-1:0] RF_data19,
    input  logic [DATA_W-1:0] RF_data20,
    input  logic [DATA_W-1:0] RF_data21,
    input  logic [DATA_W-1:0] RF_data22,
    input  logic [DATA_W-1:0] RF_data23,
    input  logic [DATA_W-1:0] RF_data24,
    input  logic [DATA_W-1:0] RF_data25,
    input  logic [DATA_W-1:0] RF_data26,
    input  logic [DATA_W-1:0] RF_data27,
    input  logic [DATA_W-1:0] RF_data28,
    input  logic [DATA_W-1:0] RF_data29,
    input  logic [DATA_W-1:0] RF_data30,
    input  logic [DATA_W-1:0] RF_data31,
    input  logic              snap_req,
    output logic              snap_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [7:0]        snap_drop_cnt
);
    import rf_snap_pkg::*;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_e              state_q, state_d;
    logic [4:0]          idx_q, idx_d;
    logic                valid_q, valid_d;
    logic [5:0]          index_q, index_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic [7:0]          drop_q, drop_d;
    logic                load;
    logic                xfer;
    logic [4:0]          idx_nxt;
    logic [DATA_W-1:0]   rd_data;
    logic [NUM_REGS-1:0][DATA_W-1:0] rf_live;
`ifdef RF_SNAP_CHECKSUM_EN
    logic [DATA_W-1:0]   sum;
`endif

    assign rf_live = {RF_data31, RF_data30, RF_data29, RF_data28, RF_data27, RF_data26, RF_data25, RF_data24,
                      RF_data23, RF_data22, RF_data21, RF_data20, RF_data19, RF_data18, RF_data17, RF_data16,
                      RF_data15, RF_data14, RF_data13, RF_data12, RF_data11, RF_data10, RF_data9,  RF_data8,
                      RF_data7,  RF_data6,  RF_data5,  RF_data4,  RF_data3,  RF_data2,  RF_data1,  RF_data0};

    // The bank is read one index ahead so the next beat can be registered on the transfer edge.
    assign idx_nxt = idx_q + 5'd1;
    assign xfer    = valid_q & out_ready;

    rf_snap_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_bank (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .wr_data_i (rf_live),
        .rd_idx_i  (idx_nxt),
        .rd_data_o (rd_data)
`ifdef RF_SNAP_CHECKSUM_EN
        ,
        .sum_o     (sum)
`endif
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        index_d = index_q;
        data_d  = data_q;
        last_d  = last_q;
        load    = 1'b0;
        drop_d  = (snap_req && state_q != IDLE && drop_q != DROP_CNT_MAX) ? drop_q + 8'd1 : drop_q;
        case (state_q)
            IDLE: if (snap_req) begin
                // Beat 0 comes straight from the live bus: the bank is loading it on this same edge.
                load    = 1'b1;
                state_d = SEND;
                idx_d   = '0;
                valid_d = 1'b1;
                index_d = '0;
                data_d  = RF_data0;
                last_d  = 1'b0;
            end
            SEND: if (xfer) begin
                if (idx_q == LAST_IDX) begin
`ifdef RF_SNAP_CHECKSUM_EN
                    state_d = SUM;
                    index_d = SUM_INDEX;
                    data_d  = sum;
                    last_d  = 1'b1;
`else
                    state_d = IDLE;
                    valid_d = 1'b0;
                    index_d = '0;
                    data_d  = '0;
                    last_d  = 1'b0;
`endif
                end else begin
                    idx_d   = idx_nxt;
                    index_d = {1'b0, idx_nxt};
                    data_d  = rd_data;
`ifdef RF_SNAP_CHECKSUM_EN
                    last_d  = 1'b0;
`else
                    last_d  = (idx_nxt == LAST_IDX);
`endif
                end
            end
`ifdef RF_SNAP_CHECKSUM_EN
            SUM: if (xfer) begin
                state_d = IDLE;
                valid_d = 1'b0;
                index_d = '0;
                data_d  = '0;
                last_d  = 1'b0;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            index_q <= index_d;
            data_q  <= data_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    assign snap_busy     = (state_q != IDLE);
    assign out_valid     = valid_q;
    assign out_index     = index_q;
    assign out_data      = data_q;
    assign out_last      = last_q;
    assign snap_drop_cnt = drop_q;
endmodule

// File: tb/tb_rf_snapshot_streamer.sv
// tb_rf_snapshot_streamer: scoreboard bench; expected beats are queued at each capture and compared every cycle.
module tb_rf_snapshot_streamer;
`ifdef RF_SNAP_CHECKSUM_EN
    localparam int BEATS = 33;
`else
    localparam int BEATS = 32;
`endif

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        snap_req = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] rf [32];
    logic        snap_busy, out_valid, out_last;
    logic [5:0]  out_index;
    logic [31:0] out_data;
    logic [7:0]  snap_drop_cnt;

    beat_t q[$];
    int    checks = 0;
    int    failures = 0;
    int    n_xfer = 0;
    bit    m_busy = 1'b0;
    int    m_drop = 0;

    always #5 clk = ~clk;

    rf_snapshot_streamer dut (
        .clk(clk), .reset(reset),
        .RF_data0(rf[0]),   .RF_data1(rf[1]),   .RF_data2(rf[2]),   .RF_data3(rf[3]),
        .RF_data4(rf[4]),   .RF_data5(rf[5]),   .RF_data6(rf[6]),   .RF_data7(rf[7]),
        .RF_data8(rf[8]),   .RF_data9(rf[9]),   .RF_data10(rf[10]), .RF_data11(rf[11]),
        .RF_data12(rf[12]), .RF_data13(rf[13]), .RF_data14(rf[14]), .RF_data15(rf[15]),
        .RF_data16(rf[16]), .RF_data17(rf[17]), .RF_data18(rf[18]), .RF_data19(rf[19]),
        .RF_data20(rf[20]), .RF_data21(rf[21]), .RF_data22(rf[22]), .RF_data23(rf[23]),
        .RF_data24(rf[24]), .RF_data25(rf[25]), .RF_data26(rf[26]), .RF_data27(rf[27]),
        .RF_data28(rf[28]), .RF_data29(rf[29]), .RF_data30(rf[30]), .RF_data31(rf[31]),
        .snap_req(snap_req), .snap_busy(snap_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_data(out_data), .out_last(out_last), .snap_drop_cnt(snap_drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_regs(input logic [31:0] base, input bit zero_r0);
        for (int i = 0; i < 32; i++) rf[i] = (zero_r0 && i == 0) ? 32'h0 : base + 32'(i);
    endtask

    task automatic capture();
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < 32; i++) begin
            q.push_back('{idx: 6'(i), data: rf[i], last: (BEATS == 32 && i == 31)});
            x = x ^ rf[i];
        end
`ifdef RF_SNAP_CHECKSUM_EN
        q.push_back('{idx: 6'd32, data: x, last: 1'b1});
`endif
        m_busy = 1'b1;
    endtask

    // Called at a negedge with inputs already driven; checks, advances the model, then steps one clock.
    task automatic cycle();
        beat_t b;
        bit    pre;
        chk("busy", 64'(snap_busy), 64'(m_busy));
        chk("valid", 64'(out_valid), 64'(m_busy));
        chk("drop_cnt", 64'(snap_drop_cnt), 64'(m_drop));
        if (m_busy && q.size() > 0) begin
            b = q[0];
            chk("index", 64'(out_index), 64'(b.idx));
            chk("data", 64'(out_data), 64'(b.data));
            chk("last", 64'(out_last), 64'(b.last));
        end
        pre = m_busy;
        if (pre && out_ready && q.size() > 0) begin
            b = q.pop_front();
            n_xfer++;
            if (b.last) m_busy = 1'b0;
        end
        if (snap_req) begin
            if (pre) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else     capture();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_busy && n < 200) begin
            cycle();
            n++;
        end
        chk("drain_done", 64'(m_busy), 64'd0);
    endtask

    initial begin
        set_regs(32'h100, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(snap_busy), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_index", 64'(out_index), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_drop", 64'(snap_drop_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        cycle();
        cycle();

        // Basic snapshot with ready held high.
        n_xfer = 0;
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        drain();
        chk("beat_count", 64'(n_xfer), 64'(BEATS));
        cycle();

        // Live registers change right after capture; stream must show captured values.
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        set_regs(32'hDEAD_0000, 1'b0);
        drain();
        set_regs(32'h100, 1'b1);
        cycle();

        // Backpressure at index 7 for 5 cycles.
        n_xfer = 0;
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_index", 64'(out_index), 64'd7);
            chk("hold_data", 64'(out_data), 64'h107);
            cycle();
        end
        out_ready = 1'b1;
        drain();
        chk("bp_beat_count", 64'(n_xfer), 64'(BEATS));
        cycle();

        // snap_req held for 40 cycles: drops accumulate, second snapshot after one idle cycle.
        set_regs(32'h200, 1'b0);
        snap_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 32) chk("drop_at_idx31", 64'(snap_drop_cnt), 64'd31);
            cycle();
        end
        snap_req = 1'b0;
        drain();
        cycle();

        // Long busy period with sink stalled: drop counter saturates.
        snap_req = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 300; i++) cycle();
        chk("drop_sat", 64'(snap_drop_cnt), 64'd255);
        snap_req = 1'b0;
        out_ready = 1'b1;
        drain();
        cycle();

        // Reset asserted while index 12 is presented.
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        chk("pre_rst_index", 64'(out_index), 64'd12);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_drop", 64'(snap_drop_cnt), 64'd0);
        chk("mid_rst_last", 64'(out_last), 64'd0);
        chk("mid_rst_busy", 64'(snap_busy), 64'd0);
        q.delete();
        m_busy = 1'b0;
        m_drop = 0;
        @(negedge clk);
        reset = 1'b1;
        n_xfer = 0;
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        drain();
        chk("post_rst_beats", 64'(n_xfer), 64'(BEATS));
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
